// File: rtl/core_pc_launcher.sv
// core_pc_launcher: walks a rectangular tile array in row-major order and
// issues one PC-write store per tile. Outstanding stores are limited by a
// credit counter, and the launcher reports done once every store is acked.
// Optional build macro CORE_LAUNCH_TIMEOUT_EN adds a stall watchdog that
// forces ERR when SEND/DRAIN make no progress for timeout_cycles_p cycles.
module core_pc_launcher #(
   parameter int unsigned x_cord_width_p    = 4,
   parameter int unsigned y_cord_width_p    = 4,
   parameter int unsigned num_tiles_x_p     = 4,
   parameter int unsigned num_tiles_y_p     = 4,
   parameter int unsigned data_width_p      = 32,
   parameter int unsigned addr_width_p      = 20,
   parameter logic [addr_width_p-1:0] pc_write_addr_p = addr_width_p'(20'h4_0000),
   parameter int unsigned max_out_credits_p = 8
`ifdef CORE_LAUNCH_TIMEOUT_EN
   ,
   parameter int unsigned timeout_cycles_p  = 1024
`endif
) (
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic                                       start_i,
   input  logic [data_width_p-1:0]                    start_pc_i,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic                                       err_o,
   output logic                                       pkt_v_o,
   output logic [x_cord_width_p-1:0]                  pkt_x_o,
   output logic [y_cord_width_p-1:0]                  pkt_y_o,
   output logic [addr_width_p-1:0]                    pkt_addr_o,
   output logic [data_width_p-1:0]                    pkt_data_o,
   input  logic                                       pkt_ready_i,
   input  logic                                       resp_v_i,
   output logic [$clog2(max_out_credits_p+1)-1:0]     out_credits_o
);

   localparam int unsigned cred_w_lp = $clog2(max_out_credits_p + 1);
   localparam logic [cred_w_lp-1:0]      cred_max_lp = cred_w_lp'(max_out_credits_p);
   localparam logic [x_cord_width_p-1:0] x_last_lp   = x_cord_width_p'(num_tiles_x_p - 1);
   localparam logic [y_cord_width_p-1:0] y_last_lp   = y_cord_width_p'(num_tiles_y_p - 1);

   typedef enum logic [2:0] {
      st_idle_e  = 3'd0,
      st_send_e  = 3'd1,
      st_drain_e = 3'd2,
      st_done_e  = 3'd3,
      st_err_e   = 3'd4
   } state_e;

   state_e                    state_q, state_d;
   logic [x_cord_width_p-1:0] x_q, x_d;
   logic [y_cord_width_p-1:0] y_q, y_d;
   logic [data_width_p-1:0]   pc_q, pc_d;
   logic [cred_w_lp-1:0]      cred_q, cred_d;
   logic                      hs;
   logic                      spurious;
   logic                      timeout_hit;

   // Request valid depends only on registered state and credits.
   assign pkt_v_o       = (state_q == st_send_e) && (cred_q != '0);
   assign hs            = pkt_v_o && pkt_ready_i;
   assign spurious      = resp_v_i && (cred_q == cred_max_lp);
   assign pkt_x_o       = x_q;
   assign pkt_y_o       = y_q;
   assign pkt_addr_o    = pc_write_addr_p;
   assign pkt_data_o    = pc_q;
   assign out_credits_o = cred_q;
   assign busy_o        = (state_q == st_send_e) || (state_q == st_drain_e);
   assign done_o        = (state_q == st_done_e);
   assign err_o         = (state_q == st_err_e);

`ifdef CORE_LAUNCH_TIMEOUT_EN
   localparam int unsigned to_w_lp = $clog2(timeout_cycles_p + 1);
   logic [to_w_lp-1:0] to_cnt_q, to_cnt_d;

   // Watchdog: counts idle cycles in SEND/DRAIN, cleared by any progress.
   always_comb begin
      to_cnt_d    = '0;
      timeout_hit = 1'b0;
      if (busy_o && !hs && !resp_v_i) begin
         to_cnt_d    = to_cnt_q + to_w_lp'(1);
         timeout_hit = (to_cnt_q == to_w_lp'(timeout_cycles_p - 1));
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, tile walk and credit accounting.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pc_d    = pc_q;
      cred_d  = cred_q;

      if (hs && !resp_v_i) begin
         cred_d = cred_q - cred_w_lp'(1);
      end else if (!hs && resp_v_i && !spurious) begin
         cred_d = cred_q + cred_w_lp'(1);
      end

      case (state_q)
         st_idle_e, st_done_e: begin
            if (start_i) begin
               pc_d    = start_pc_i;
               x_d     = '0;
               y_d     = '0;
               state_d = st_send_e;
            end
         end
         st_send_e: begin
            if (hs) begin
               if (x_q == x_last_lp) begin
                  x_d = '0;
                  if (y_q == y_last_lp) state_d = st_drain_e;
                  else                  y_d     = y_q + y_cord_width_p'(1);
               end else begin
                  x_d = x_q + x_cord_width_p'(1);
               end
            end
         end
         st_drain_e: begin
            if (cred_q == cred_max_lp) state_d = st_done_e;
         end
         st_err_e: state_d = st_err_e;
         default:  state_d = st_err_e;
      endcase

      // An ack with nothing outstanding or a stalled launch is fatal.
      if (spurious || timeout_hit) state_d = st_err_e;
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= st_idle_e;
         x_q     <= '0;
         y_q     <= '0;
         pc_q    <= '0;
         cred_q  <= cred_max_lp;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pc_q    <= pc_d;
         cred_q  <= cred_d;
      end
   end

endmodule
